// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter/sequencer sharing one 16:1 register-file read mux among four requesters.
// Optional macro RF_ARB_LOCK_EN adds a lock input that holds the priority pointer on the granted requester.
module rf_read_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef RF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock,
`endif
  input  logic [NUM_REQ-1:0]    req,
  input  logic [4*NUM_REQ-1:0]  raddr,
  input  logic [DATA_WIDTH-1:0] mux_y,
  output logic [3:0]            sel,
  output logic [NUM_REQ-1:0]    grant,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [1:0]            rid
);

  typedef enum logic [1:0] {IDLE, ADDR, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            rid_q, rid_d;
  logic [3:0]            sel_q, sel_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic [3:0]            raddr_slice [NUM_REQ];
  logic [1:0]            winner;
  logic [1:0]            cand;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign raddr_slice[gi] = raddr[4*gi +: 4];
    end
  endgenerate

  // Scan offsets from far to near so the offset closest to ptr wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) winner = cand;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rid_d    = rid_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    grant_d  = '0;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          rid_d   = winner;
          sel_d   = raddr_slice[winner];
          state_d = ADDR;
        end
      end
      ADDR: begin
        rdata_d  = mux_y;
        rvalid_d = 1'b1;
        grant_d  = NUM_REQ'(1) << rid_q;
        state_d  = DONE;
      end
      DONE: begin
`ifdef RF_ARB_LOCK_EN
        if (!lock[rid_q]) ptr_d = rid_q + 2'd1;
`else
        ptr_d = rid_q + 2'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rid_q    <= '0;
      sel_q    <= '0;
      grant_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rid_q    <= rid_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign sel    = sel_q;
  assign grant  = grant_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;

endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 16-entry, 32-bit register-file read mux among four requesters. It picks one requester and latches that requester's 4-bit read address. It drives the mux select lines s3..s0, captures the mux output and returns the data with a one-cycle valid/grant pulse. It sits between the requesting units and the 16:1 read mux.

Parameters:
DATA_WIDTH, 32, width of mux_y and rdata.
NUM_REQ, 4, number of requesters. Fixed at 4; other values are unsupported.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  4  request per requester; held high until that requester's grant pulse.
raddr  input  16  packed read addresses; raddr[4*i+3:4*i] belongs to requester i.
mux_y  input  DATA_WIDTH  output of the 16:1 read mux.
sel  output  4  mux select; sel[3:0] drives s3,s2,s1,s0.
grant  output  4  one-hot, one-cycle pulse marking the completed requester.
rdata  output  DATA_WIDTH  captured read data.
rvalid  output  1  one-cycle pulse; rdata is valid.
rid  output  2  index of the requester that owns rdata.

Behaviour:
- Reset: asynchronous, active-high. While reset=1:
  - state=IDLE, sel=0, grant=0, rdata=0, rvalid=0, rid=0.
  - priority pointer ptr=0.
  - Applies mid-transaction; the in-flight read is dropped with no grant.
- State machine: IDLE -> ADDR -> DONE -> IDLE.
- IDLE:
  - If req==0, stay in IDLE; outputs hold, except rvalid=0 and grant=0.
  - Otherwise, winner = first set req bit searching ptr, ptr+1, ... mod 4.
  - Register rid<=winner and sel<=raddr slice of winner, then go to ADDR.
- ADDR:
  - sel is stable; mux_y is combinationally valid.
  - At the clock edge: rdata<=mux_y, rvalid<=1, grant<=(1<<rid), go to DONE.
- DONE:
  - rvalid=1 and grant one-hot for exactly this cycle.
  - ptr<=rid+1 mod 4; go to IDLE.
  - rvalid and grant clear on the next edge.
- Latency: req sampled high in IDLE at edge N -> rvalid/grant high in cycle N+2. Peak throughput is one read per 3 cycles.
- The address is latched at the arbitration edge. Later changes to raddr, or a req drop during ADDR/DONE, do not affect the transaction; it completes and grants normally.
- Requester rule: drop req in the cycle after seeing its grant. Arbitration occurs only in IDLE, one cycle after DONE, so the just-served req is never re-sampled.
- Simultaneous requests: exactly one winner per arbitration; the others stay pending with no grant.
- ptr wrap: 3+1 -> 0.
- sel and rdata hold their last values between transactions; only rvalid and grant return to 0.

Optional Feature:
- Macro: RF_ARB_LOCK_EN.
- With the macro defined:
  - Adds input port lock, width 4.
  - If lock[rid]=1 in DONE, ptr is left unchanged instead of advancing. The locked requester then keeps highest priority in the next arbitration (back-to-back reads).
  - lock bits of non-granted requesters are ignored.
- Without the macro: no lock port; ptr always advances to rid+1.

Test Plan:
- Reset, then req=4'b0001 with raddr[3:0]=4'h5 and mux_y following a model where reg k = 32'h100+k -> sel=4'h5 in cycle N+1; rvalid=1, rdata=32'h105, grant=4'b0001, rid=0 in cycle N+2.
- req=4'b1111 held continuously, each requester dropping req after its grant -> grant order 0001, 0010, 0100, 1000, one every 3 cycles.
- After serving requester 3, req=4'b1001 -> ptr wrap: requester 0 granted before the next requester 3 request.
- raddr changed and req dropped during ADDR -> rdata reflects the address latched in IDLE; grant still pulses.
- reset asserted during ADDR -> rvalid, grant, sel and rdata immediately 0; after release, req=4'b0110 grants requester 1 first (ptr=0).
- RF_ARB_LOCK_EN defined: req=4'b0011 with lock=4'b0001 held -> requester 0 granted repeatedly; once lock=0, requester 1 is granted next.
